// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, framing-error and break handling
module uart_rx #(
  parameter int CLOCK_MHZ = 16,
  parameter int BAUD_RATE = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CLKS_PER_BIT = CLOCK_MHZ * 1_000_000 / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;
  logic             rx_s;

  // Second synchroniser stage is the only view of the line the FSM uses.
  assign rx_s = sync_q[1];

  // Next-state logic: line synchroniser, bit timing, shift register and output strobes.
  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[0], i_uart_rx};
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          // Mid start bit: a line already back high was only a glitch.
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BREAK: begin
        // A held-low line must return high before another start is accepted.
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset aborts any frame in flight without a pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx driving directed serial frames
module tb_uart_rx;

  localparam int BIT_CYC = 138;
  localparam int LAT_NOM = 1315;
  localparam int LAT_TOL = 2;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         start;
    logic [7:0] data;
    bit         err;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_data = 8'h00;
  int         n_valid = 0;
  int         n_err = 0;
  int         n_busy_rise = 0;
  logic       busy_prev = 1'b0;

  uart_rx dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_uart_rx  (rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame; when expected, the model records what the receiver must report.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_cyc, input bit expected);
    exp_t e;
    if (expected) begin
      e.start = cyc;
      e.data  = b;
      e.err   = !stop;
      exp_q.push_back(e);
    end
    rx = 1'b0;
    wait_cyc(bit_cyc);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(bit_cyc);
    end
    rx = stop;
    wait_cyc(bit_cyc);
  endtask

  // Compare process: every pulse must match the oldest expected frame in kind, data and latency.
  always @(negedge clk) begin
    int   lat;
    exp_t e;
    if (o_busy && !busy_prev) n_busy_rise++;
    busy_prev = o_busy;
    if (!rst_n) begin
      model_data = 8'h00;
    end else if (o_valid || o_frame_err) begin
      chk("valid_err_exclusive", {31'd0, o_valid & o_frame_err}, 32'd0);
      if (o_valid) n_valid++;
      if (o_frame_err) n_err++;
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, o_valid, o_frame_err}, 32'd0);
      end else begin
        e   = exp_q.pop_front();
        lat = cyc - e.start;
        checks++;
        if (lat < LAT_NOM - LAT_TOL || lat > LAT_NOM + LAT_TOL) begin
          errors++;
          $display("FAIL pulse_latency: got %0d cycles expected %0d +/- %0d", lat, LAT_NOM, LAT_TOL);
        end
        chk("pulse_kind_valid", {31'd0, o_valid}, {31'd0, !e.err});
        if (!e.err) model_data = e.data;
      end
    end else if (exp_q.size() > 0 && cyc > exp_q[0].start + LAT_NOM + LAT_TOL) begin
      e = exp_q.pop_front();
      chk("missing_pulse", 32'd0, {24'd0, e.data});
    end
    chk("o_data_model", {24'd0, o_data}, {24'd0, model_data});
  end

  initial begin
    int base;
    rx    = 1'b1;
    rst_n = 1'b0;
    wait_cyc(3);
    chk("reset_data", {24'd0, o_data}, 32'h00);
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_ferr", {31'd0, o_frame_err}, 32'd0);
    chk("reset_busy", {31'd0, o_busy}, 32'd0);
    rst_n = 1'b1;
    wait_cyc(10);

    // Single byte.
    send_frame(8'h55, 1'b1, BIT_CYC, 1'b1);
    wait_cyc(5);
    chk("b55_data", {24'd0, o_data}, 32'h55);
    chk("b55_nvalid", n_valid, 1);
    chk("b55_nerr", n_err, 0);

    // Back-to-back frames, busy must drop and rise again for each.
    base = n_busy_rise;
    send_frame(8'h00, 1'b1, BIT_CYC, 1'b1);
    send_frame(8'hFF, 1'b1, BIT_CYC, 1'b1);
    send_frame(8'hA5, 1'b1, BIT_CYC, 1'b1);
    send_frame(8'h3C, 1'b1, BIT_CYC, 1'b1);
    wait_cyc(5);
    chk("b2b_nvalid", n_valid, 5);
    chk("b2b_data", {24'd0, o_data}, 32'h3C);
    chk("b2b_busy_rises", n_busy_rise - base, 4);

    // Framing error, then line held low for three frame times.
    send_frame(8'hC3, 1'b0, BIT_CYC, 1'b1);
    wait_cyc(3 * 10 * BIT_CYC);
    chk("ferr_nerr", n_err, 1);
    chk("ferr_nvalid", n_valid, 5);
    chk("ferr_data_kept", {24'd0, o_data}, 32'h3C);
    chk("break_busy", {31'd0, o_busy}, 32'd1);
    rx = 1'b1;
    wait_cyc(20);
    chk("break_exit_busy", {31'd0, o_busy}, 32'd0);
    send_frame(8'h12, 1'b1, BIT_CYC, 1'b1);
    wait_cyc(5);
    chk("after_break_data", {24'd0, o_data}, 32'h12);
    chk("after_break_nvalid", n_valid, 6);

    // 20-cycle low glitch on an idle line.
    rx = 1'b0;
    wait_cyc(5);
    chk("glitch_busy_high", {31'd0, o_busy}, 32'd1);
    wait_cyc(15);
    rx = 1'b1;
    wait_cyc(2 + 69 + 3 - 20);
    chk("glitch_busy_low", {31'd0, o_busy}, 32'd0);
    wait_cyc(50);
    chk("glitch_no_pulse", n_valid + n_err, 7);

    // Reset during data bit 4 of 0xF0; the aborted frame must yield nothing.
    rx = 1'b0;
    wait_cyc(BIT_CYC);
    wait_cyc(4 * BIT_CYC);
    rx = 1'b1;
    wait_cyc(30);
    chk("pre_reset_busy", {31'd0, o_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", {31'd0, o_busy}, 32'd0);
    chk("midreset_data", {24'd0, o_data}, 32'h00);
    wait_cyc(10);
    rst_n = 1'b1;
    wait_cyc(5 * BIT_CYC);
    chk("midreset_no_pulse", n_valid + n_err, 7);
    send_frame(8'h7E, 1'b1, BIT_CYC, 1'b1);
    wait_cyc(5);
    chk("after_reset_data", {24'd0, o_data}, 32'h7E);

    // Baud mismatch: 2% fast and 2% slow transmitters.
    send_frame(8'h96, 1'b1, 135, 1'b1);
    wait_cyc(5);
    chk("fast_data", {24'd0, o_data}, 32'h96);
    chk("fast_nvalid", n_valid, 8);
    wait_cyc(20);
    send_frame(8'h96, 1'b1, 141, 1'b1);
    wait_cyc(5);
    chk("slow_data", {24'd0, o_data}, 32'h96);
    chk("slow_nvalid", n_valid, 9);

    wait_cyc(50);
    chk("queue_drained", exp_q.size(), 0);
    chk("total_ferr", n_err, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the 8N1 UART link: the stage directly downstream of `uart_tx`, consuming the serial line it drives. It synchronises the asynchronous line and detects start bits. It samples each bit at mid-point, then presents each received byte with a one-cycle valid strobe, or flags a framing error. Used for loopback testing of the transmitter and as the host-to-FPGA command path.

## Interface

- `CLOCK_MHZ`, 16, system clock frequency in MHz.
- `BAUD_RATE`, 115200, line rate in bits/s.
- `CLKS_PER_BIT` (localparam), `CLOCK_MHZ*1_000_000/BAUD_RATE`, integer-truncated; 138 at defaults.
- `HALF_BIT` (localparam), `CLKS_PER_BIT/2`, integer-truncated; 69 at defaults.

Ports:

- `i_clk` input 1: system clock. This is the only clock.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_uart_rx` input 1: serial line. It is asynchronous to `i_clk` and idles high.
- `o_data` output 8: last received byte. Holds its value until the next frame completes.
- `o_valid` output 1: one-cycle pulse when `o_data` holds a newly received, correctly framed byte.
- `o_frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `o_busy` output 1: high whenever the state is not IDLE.

## Operation

- Two-flop synchroniser on `i_uart_rx`, with both flops reset to 1. All decisions use the synchronised signal `rx_s`.
- A bit counter (0..7), a cycle counter (width ≥ clog2(`CLKS_PER_BIT`)) and an 8-bit shift register.
- States:
  - IDLE: when `rx_s`==0, clear the cycle counter and go to START.
  - START: count `HALF_BIT`-1 cycles, then sample. If `rx_s`==0, go to DATA with the counter cleared. If `rx_s`==1, treat it as a glitch and return to IDLE with no output pulse.
  - DATA: every `CLKS_PER_BIT` cycles, sample `rx_s` into the shift register. Data is LSB first, shifting right and inserting at bit 7. After the 8th sample, go to STOP.
  - STOP: after `CLKS_PER_BIT` cycles, sample `rx_s`.
    - If 1: load `o_data`, pulse `o_valid`, go to IDLE.
    - If 0: pulse `o_frame_err`, leave `o_data` unchanged, go to BREAK.
  - BREAK: wait until `rx_s`==1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- `o_valid` and `o_frame_err` are never high in the same cycle. Neither is ever high for more than one cycle.
- The receiver has no backpressure. The consumer must capture `o_data` within one frame time, since it is overwritten only by the next valid frame.

## Timing

- Reset values: `o_data`=8'h00, `o_valid`=0, `o_frame_err`=0, `o_busy`=0, state=IDLE, synchroniser=2'b11, all counters=0.
- Reset asserted mid-frame: return to IDLE immediately with no pulse. After release, the receiver needs `rx_s`==1 followed by a falling edge before it receives again.
- Detection latency: 2 cycles from a line edge to `rx_s`.
- Sample points:
  - Start bit: `HALF_BIT` cycles after entering START.
  - Data bit k (k=0..7): (k+1)·`CLKS_PER_BIT` cycles after that.
  - Stop bit: 9·`CLKS_PER_BIT` cycles after that.
- `o_valid` or `o_frame_err` rises the cycle after the stop sample. At defaults this is nominally 2+1+69+9·138+1 = 1315 cycles after the start-bit falling edge on `i_uart_rx`. The bench tolerance is ±2 cycles.
- `o_busy` rises the cycle after `rx_s` first reads 0. It falls in the same cycle that `o_valid` pulses, or on leaving BREAK.
- Back-to-back frames are supported: a start edge immediately after the stop bit (line high ≥1 cycle in IDLE) is received.
- The sample point stays within the bit for baud mismatch up to ±2%.

## Test plan

- Reset with line high: all outputs at reset values. Send 0x55 at 115200 baud → exactly one `o_valid` pulse about 1315 cycles after the start edge, `o_data`=0x55, no `o_frame_err`.
- Loopback from `uart_tx` with the same parameters, bytes 0x00, 0xFF, 0xA5, 0x3C sent back-to-back → four `o_valid` pulses with matching data in order, `o_busy` toggling between frames.
- Stop bit forced low on byte 0xC3 → one `o_frame_err` pulse, no `o_valid`, `o_data` keeps its previous value. Hold the line low for 3 frame times → no further pulses. Release the line, then send 0x12 → `o_valid` with 0x12.
- Low glitch of 20 cycles on an idle line → no pulse, state back to IDLE (`o_busy` low) within `HALF_BIT`+3 cycles.
- Assert `i_rst_n` low during data bit 4 of a frame → outputs reset immediately and no pulse for that frame. The next full frame 0x7E → `o_valid` with 0x7E.
- Transmit 0x96 at a baud rate 2% fast and 2% slow → `o_data`=0x96 in both cases.
